// File: rtl/aes_key_expansion.sv
// Iterative AES-128 key schedule: latches a cipher key on start and streams
// round keys 0..10, one per clock, computing each next key combinationally.
module aes_key_expansion (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [127:0] cipherKey,
  output logic         busy,
  output logic         keyValid,
  output logic [3:0]   roundIndex,
  output logic [127:0] roundKey,
  output logic         done
);

  typedef enum logic [0:0] {StIdle, StExpand} state_e;

  state_e       state_q, state_d;
  logic [127:0] key_q, key_d;
  logic [7:0]   rcon_q, rcon_d;
  logic [3:0]   cnt_q, cnt_d;

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Multiplicative inverse as x^254 (product of x^2..x^128), then the affine map.
  function automatic logic [7:0] s_box(input logic [7:0] x);
    logic [7:0] sq;
    logic [7:0] inv;
    sq  = x;
    inv = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]} ^
           {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  logic [31:0]  w0, w1, w2, w3;
  logic [31:0]  rot_w3, sub_w3, t_word;
  logic [31:0]  nw0, nw1, nw2, nw3;
  logic [127:0] next_key;
  logic [7:0]   rcon_next;

  assign w0     = key_q[127:96];
  assign w1     = key_q[95:64];
  assign w2     = key_q[63:32];
  assign w3     = key_q[31:0];
  assign rot_w3 = {w3[23:0], w3[31:24]};

  for (genvar g = 0; g < 4; g++) begin : g_s_box
    assign sub_w3[8*g +: 8] = s_box(rot_w3[8*g +: 8]);
  end

  assign t_word    = sub_w3 ^ {rcon_q, 24'h0};
  assign nw0       = w0 ^ t_word;
  assign nw1       = w1 ^ nw0;
  assign nw2       = w2 ^ nw1;
  assign nw3       = w3 ^ nw2;
  assign next_key  = {nw0, nw1, nw2, nw3};
  assign rcon_next = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);

  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    rcon_d  = rcon_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StExpand;
          key_d   = cipherKey;
          rcon_d  = 8'h01;
          cnt_d   = 4'd0;
        end
      end
      StExpand: begin
        if (cnt_q == 4'd10) begin
          state_d = StIdle;
        end else begin
          key_d  = next_key;
          rcon_d = rcon_next;
          cnt_d  = cnt_q + 4'd1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      key_q   <= 128'h0;
      rcon_q  <= 8'h01;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      rcon_q  <= rcon_d;
      cnt_q   <= cnt_d;
    end
  end

  // Key register and counter hold after round 10, so IDLE keeps showing them.
  assign keyValid   = (state_q == StExpand);
  assign busy       = (state_q == StExpand);
  assign done       = (state_q == StExpand) && (cnt_q == 4'd10);
  assign roundKey   = key_q;
  assign roundIndex = cnt_q;

endmodule

// File: tb/tb_aes_key_expansion.sv
// Self-checking bench for aes_key_expansion: FIPS-197 and zero-key vectors, ignored
// restarts, asynchronous reset, held start and a random-key reference scoreboard.
module tb_aes_key_expansion;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [127:0] cipherKey;
  logic         busy;
  logic         keyValid;
  logic [3:0]   roundIndex;
  logic [127:0] roundKey;
  logic         done;

  int total = 0;
  int bad   = 0;

  localparam logic [127:0] FipsKey = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] ZeroKey = 128'h0;

  logic [7:0]   sbox_tab [256];
  logic [7:0]   rc_tab   [11];
  logic [127:0] exp_rk   [11];
  logic [127:0] obs_rk   [11];
  logic [127:0] fips_rk  [11];
  logic [127:0] zero_rk  [11];
  logic [7:0]   obs_rcon [11];

  aes_key_expansion dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .cipherKey  (cipherKey),
    .busy       (busy),
    .keyValid   (keyValid),
    .roundIndex (roundIndex),
    .roundKey   (roundKey),
    .done       (done)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] mul(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] prod;
    prod = 16'h0;
    for (int i = 0; i < 8; i++) if (b[i]) prod = prod ^ (16'(a) << i);
    for (int i = 15; i >= 8; i--) if (prod[i]) prod = prod ^ (16'h011b << (i - 8));
    return prod[7:0];
  endfunction

  // S-box by exhaustive inverse search plus the FIPS-197 affine bit formula.
  task automatic build_tables();
    logic [7:0] inv;
    logic [7:0] s;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) if (mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      for (int i = 0; i < 8; i++)
        s[i] = inv[i] ^ inv[(i + 4) % 8] ^ inv[(i + 5) % 8] ^ inv[(i + 6) % 8] ^
               inv[(i + 7) % 8] ^ (((8'h63 >> i) & 8'h01) != 0);
      sbox_tab[x] = s;
    end
    rc_tab[0] = 8'h00;
    rc_tab[1] = 8'h01;
    for (int i = 2; i < 11; i++) rc_tab[i] = mul(rc_tab[i-1], 8'h02);
  endtask

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox_tab[w[31:24]], sbox_tab[w[23:16]], sbox_tab[w[15:8]], sbox_tab[w[7:0]]};
  endfunction

  task automatic model_expand(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] temp;
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      temp = w[i-1];
      if (i % 4 == 0)
        temp = sub_word({temp[23:0], temp[31:24]}) ^ {rc_tab[i/4], 24'h0};
      w[i] = w[i-4] ^ temp;
    end
    for (int r = 0; r < 11; r++) exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    total++;
    assert (obs === expv)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full run from IDLE; optional restart attempts with a different key at rounds 3 and 7.
  task automatic check_run(input logic [127:0] key, input bit interfere, input bit full);
    int n_valid;
    int n_busy;
    int n_done;
    logic [7:0] sb;
    model_expand(key);
    n_valid = 0;
    n_busy  = 0;
    n_done  = 0;
    start     = 1'b1;
    cipherKey = key;
    tick();
    start = 1'b0;
    for (int k = 0; k < 11; k++) begin
      n_valid += int'(keyValid);
      n_busy  += int'(busy);
      n_done  += int'(done);
      obs_rk[k] = roundKey;
      if (k > 0) begin
        sb = sbox_tab[obs_rk[k-1][23:16]];
        obs_rcon[k] = roundKey[127:120] ^ obs_rk[k-1][127:120] ^ sb;
      end
      chk($sformatf("key_r%0d", k), roundKey, exp_rk[k]);
      if (full) begin
        chk($sformatf("idx_r%0d", k), 128'(roundIndex), 128'(k));
        chk($sformatf("valid_r%0d", k), 128'(keyValid), 128'd1);
        chk($sformatf("done_r%0d", k), 128'(done), 128'(k == 10));
      end
      start     = interfere && (k == 3 || k == 7);
      cipherKey = (interfere && (k == 3 || k == 7)) ? ~key : key;
      tick();
    end
    start = 1'b0;
    n_valid += int'(keyValid);
    n_busy  += int'(busy);
    n_done  += int'(done);
    chk("valid_count", 128'(n_valid), 128'd11);
    chk("busy_count", 128'(n_busy), 128'd11);
    chk("done_count", 128'(n_done), 128'd1);
    chk("idle_valid", 128'(keyValid), 128'd0);
    chk("idle_index", 128'(roundIndex), 128'd10);
    chk("idle_key", roundKey, exp_rk[10]);
  endtask

  initial begin
    build_tables();
    model_expand(FipsKey);
    for (int r = 0; r < 11; r++) fips_rk[r] = exp_rk[r];
    model_expand(ZeroKey);
    for (int r = 0; r < 11; r++) zero_rk[r] = exp_rk[r];

    reset     = 1'b0;
    start     = 1'b0;
    cipherKey = FipsKey;
    tick();
    tick();
    chk("rst_valid", 128'(keyValid), 128'd0);
    chk("rst_busy", 128'(busy), 128'd0);
    chk("rst_done", 128'(done), 128'd0);
    chk("rst_index", 128'(roundIndex), 128'd0);
    chk("rst_key", roundKey, 128'h0);
    reset = 1'b1;
    tick();
    chk("post_rst_idle", 128'(keyValid), 128'd0);

    // FIPS-197 vector
    check_run(FipsKey, 1'b0, 1'b1);
    chk("fips_r0", obs_rk[0], FipsKey);
    chk("fips_r1", obs_rk[1], 128'ha0fafe1788542cb123a339392a6c7605);
    chk("fips_r10", obs_rk[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

    // All-zero key, including rcon recovered from the output stream
    tick();
    check_run(ZeroKey, 1'b0, 1'b1);
    chk("zero_r1", obs_rk[1], 128'h62636363626363636263636362636363);
    chk("zero_r10", obs_rk[10], 128'hb4ef5bcb3e92e21123e951cf6f8f188e);
    chk("rcon_r1", 128'(obs_rcon[1]), 128'h01);
    chk("rcon_r9", 128'(obs_rcon[9]), 128'h1b);
    chk("rcon_r10", 128'(obs_rcon[10]), 128'h36);

    // Restart pulses mid-run are ignored
    tick();
    check_run(FipsKey, 1'b1, 1'b1);
    for (int r = 0; r < 11; r++) chk($sformatf("intf_r%0d", r), obs_rk[r], fips_rk[r]);

    // Asynchronous reset during round 5
    tick();
    start     = 1'b1;
    cipherKey = FipsKey;
    tick();
    start = 1'b0;
    for (int k = 0; k < 5; k++) tick();
    chk("pre_rst_idx", 128'(roundIndex), 128'd5);
    #2 reset = 1'b0;
    #1;
    chk("arst_valid", 128'(keyValid), 128'd0);
    chk("arst_busy", 128'(busy), 128'd0);
    chk("arst_done", 128'(done), 128'd0);
    chk("arst_index", 128'(roundIndex), 128'd0);
    chk("arst_key", roundKey, 128'h0);
    tick();
    reset = 1'b1;
    tick();
    check_run(FipsKey, 1'b0, 1'b0);
    chk("arst_fips_r1", obs_rk[1], 128'ha0fafe1788542cb123a339392a6c7605);

    // start held high: back-to-back runs with one idle cycle between them
    tick();
    start     = 1'b1;
    cipherKey = FipsKey;
    tick();
    for (int c = 0; c < 30; c++) begin
      if (c % 12 == 11) begin
        chk($sformatf("held_gap_c%0d", c), 128'(keyValid), 128'd0);
      end else begin
        chk($sformatf("held_valid_c%0d", c), 128'(keyValid), 128'd1);
        chk($sformatf("held_idx_c%0d", c), 128'(roundIndex), 128'(c % 12));
        chk($sformatf("held_key_c%0d", c), roundKey,
            ((c / 12) % 2 == 0) ? fips_rk[c % 12] : zero_rk[c % 12]);
      end
      if (c == 0 || c == 24) cipherKey = ZeroKey;
      if (c == 12) cipherKey = FipsKey;
      tick();
    end
    start = 1'b0;
    for (int c = 0; c < 6; c++) tick();
    chk("held_end_idle", 128'(keyValid), 128'd0);
    chk("held_end_key", roundKey, fips_rk[10]);

    // Random-key scoreboard
    for (int n = 0; n < 200; n++) begin
      tick();
      check_run({$urandom, $urandom, $urandom, $urandom}, 1'b0, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
